// File: rtl/texture_pkg.sv
// Shared types and constants for the texture tile renderer.
//   rgb444_t        : 4-bit-per-channel colour payload
//   BG_COLOR        : colour shown outside the texture footprint
//   PAL_IDX_W       : width of a texel palette index
//   palette_lookup  : palette index -> rgb444 colour
//   texel_init      : texture bank ROM contents, one palette index per texel
package texture_pkg;

  localparam int unsigned PAL_IDX_W = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam rgb444_t BG_COLOR = '{r: 4'h1, g: 4'h2, b: 4'h3};

  // 16-entry palette: red ramps up, green ramps down, blue steps by 3.
  function automatic rgb444_t palette_lookup(input logic [PAL_IDX_W-1:0] idx);
    rgb444_t c;
    c.r = 4'(idx);
    c.g = 4'hF - 4'(idx);
    c.b = 4'(idx + (idx << 1));
    return c;
  endfunction

  // Texel (u, v) of texture t holds palette index (u + 2v + 5t) mod 16.
  function automatic logic [PAL_IDX_W-1:0] texel_init(input int unsigned addr,
                                                      input int unsigned tex_w,
                                                      input int unsigned tex_h);
    int unsigned u;
    int unsigned v;
    int unsigned t;
    u = addr % tex_w;
    v = (addr / tex_w) % tex_h;
    t = addr / (tex_w * tex_h);
    return PAL_IDX_W'(u + 2 * v + 5 * t);
  endfunction

endpackage

// File: rtl/texture_bank_rom.sv
// Synchronous texture bank ROM: one palette index per texel, all textures
// stored back to back (texture-major, then row, then column).
//   clk    : read clock
//   addr_i : texel address, registered read
//   data_o : palette index, valid one cycle after addr_i
module texture_bank_rom
  import texture_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TEX_W  = 16,
  parameter int unsigned TEX_H  = 16
) (
  input  logic                 clk,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [PAL_IDX_W-1:0] data_o
);

  logic [PAL_IDX_W-1:0] rom [DEPTH];
  logic [PAL_IDX_W-1:0] rd_d;
  logic [PAL_IDX_W-1:0] rd_q;

  // Constant table contents.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
    assign rom[i] = texel_init(32'(i), TEX_W, TEX_H);
  end

  always_comb begin
    rd_d = rom[addr_i];
  end

  always_ff @(posedge clk) begin
    rd_q <= rd_d;
  end

  assign data_o = rd_q;

endmodule

// File: rtl/texture_tile_renderer.sv
// Texture tile renderer: 3-stage pixel pipeline that maps the current VGA
// coordinate onto a (possibly scaled, possibly tiled) texture and outputs a
// registered rgb444 colour.
//   vga_clk, reset        : pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank   : current pixel and active-video flag
//   tex_sel               : texture request, taken only at pixel (0,0)
//   tile_en               : 1 = repeat texture, 0 = single copy at origin
//   origin_x, origin_y    : screen position of texel (0,0)
//   red, green, blue      : registered colour, 3 cycles after the sample
//   pixel_opaque          : 1 when the colour came from the texture
// Optional: define TEXTURE_TRANSPARENCY_EN to make palette index 0 transparent.
module texture_tile_renderer
  import texture_pkg::*;
#(
  parameter int unsigned TEX_W      = 16,
  parameter int unsigned TEX_H      = 16,
  parameter int unsigned NUM_TEX    = 4,
  parameter int unsigned SCALE_LOG2 = 0
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic [$clog2(NUM_TEX)-1:0] tex_sel,
  input  logic                       tile_en,
  input  logic [9:0]                 origin_x,
  input  logic [9:0]                 origin_y,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue,
  output logic                       pixel_opaque
);

  localparam int unsigned SEL_W  = $clog2(NUM_TEX);
  localparam int unsigned U_W    = $clog2(TEX_W);
  localparam int unsigned V_W    = $clog2(TEX_H);
  localparam int unsigned DEPTH  = NUM_TEX * TEX_W * TEX_H;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned SPAN_X = TEX_W << SCALE_LOG2;
  localparam int unsigned SPAN_Y = TEX_H << SCALE_LOG2;

  // Stage 0 state
  logic [SEL_W-1:0]  tex_active_d, tex_active_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              blank0_d, blank0_q;
  logic              inside0_d, inside0_q;
  // Stage 1 state (ROM data register lives in the ROM)
  logic              blank1_d, blank1_q;
  logic              inside1_d, inside1_q;
  logic [PAL_IDX_W-1:0] rom_idx;
  // Stage 2 state
  rgb444_t           pix_d, pix_q;
  logic              opq_d, opq_q;

  logic [9:0]     dx, dy;
  logic [U_W-1:0] u;
  logic [V_W-1:0] v;
  logic [10:0]    px, py, x_lo, x_hi, y_lo, y_hi;
  logic           frame_start, sel_ok;

  // Stage 0: coordinate -> texel address, footprint test, frame-boundary texture load.
  always_comb begin
    dx = DrawX - origin_x;
    dy = DrawY - origin_y;
    u  = U_W'(dx >> SCALE_LOG2);
    v  = V_W'(dy >> SCALE_LOG2);

    // 11-bit compares so origin + span never wraps back onto the screen.
    px   = {1'b0, DrawX};
    py   = {1'b0, DrawY};
    x_lo = {1'b0, origin_x};
    y_lo = {1'b0, origin_y};
    x_hi = x_lo + 11'(SPAN_X);
    y_hi = y_lo + 11'(SPAN_Y);
    inside0_d = tile_en | ((px >= x_lo) & (px < x_hi) & (py >= y_lo) & (py < y_hi));

    // The new texture already applies to pixel (0,0) of the new frame.
    frame_start  = (DrawX == 10'd0) && (DrawY == 10'd0);
    sel_ok       = 32'(tex_sel) < NUM_TEX;
    tex_active_d = (frame_start && sel_ok) ? tex_sel : tex_active_q;

    addr_d   = ADDR_W'(32'(tex_active_d) * TEX_W * TEX_H + 32'(v) * TEX_W + 32'(u));
    blank0_d = blank;
  end

  texture_bank_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .TEX_W  (TEX_W),
    .TEX_H  (TEX_H)
  ) u_rom (
    .clk    (vga_clk),
    .addr_i (addr_q),
    .data_o (rom_idx)
  );

  // Stage 1: flags travel alongside the ROM read.
  always_comb begin
    blank1_d  = blank0_q;
    inside1_d = inside0_q;
  end

  // Stage 2: palette mapping with blanking and background override.
  always_comb begin
    pix_d = '0;
    opq_d = 1'b0;
    if (blank1_q) begin
      if (!inside1_q) begin
        pix_d = BG_COLOR;
      end else begin
`ifdef TEXTURE_TRANSPARENCY_EN
        if (rom_idx == '0) begin
          pix_d = BG_COLOR;
        end else begin
          pix_d = palette_lookup(rom_idx);
          opq_d = 1'b1;
        end
`else
        pix_d = palette_lookup(rom_idx);
        opq_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      tex_active_q <= '0;
      addr_q       <= '0;
      blank0_q     <= 1'b0;
      inside0_q    <= 1'b0;
      blank1_q     <= 1'b0;
      inside1_q    <= 1'b0;
      pix_q        <= '0;
      opq_q        <= 1'b0;
    end else begin
      tex_active_q <= tex_active_d;
      addr_q       <= addr_d;
      blank0_q     <= blank0_d;
      inside0_q    <= inside0_d;
      blank1_q     <= blank1_d;
      inside1_q    <= inside1_d;
      pix_q        <= pix_d;
      opq_q        <= opq_d;
    end
  end

  assign red          = pix_q.r;
  assign green        = pix_q.g;
  assign blue         = pix_q.b;
  assign pixel_opaque = opq_q;

endmodule

// File: tb/tb_texture_tile_renderer.sv
// Scoreboard bench: two renderers (SCALE_LOG2 = 1 and 0, NUM_TEX = 3) share
// stimulus; each driven sample pushes its hand-computed expectation, tagged
// with the clock edge at which it must appear, and a monitor pops and compares.
module tb_texture_tile_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY, origin_x, origin_y;
  logic       blank, tile_en;
  logic [1:0] tex_sel;

  logic [3:0] r1, g1, b1, r0, g0, b0;
  logic       o1, o0;

  typedef struct {
    int          target;
    bit          chk;
    logic [11:0] rgb;
    logic        opq;
    int          id;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int edge_cnt = 0;
  int n_cmp    = 0;
  int n_err    = 0;
  int vec_id   = 0;

  localparam logic [11:0] BG = 12'h123;
`ifdef TEXTURE_TRANSPARENCY_EN
  localparam logic [11:0] E0_RGB = 12'h123;
  localparam logic        E0_OPQ = 1'b0;
`else
  localparam logic [11:0] E0_RGB = 12'h0F0;
  localparam logic        E0_OPQ = 1'b1;
`endif

  texture_tile_renderer #(.TEX_W(16), .TEX_H(16), .NUM_TEX(3), .SCALE_LOG2(1)) u_s1 (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .tex_sel(tex_sel), .tile_en(tile_en), .origin_x(origin_x), .origin_y(origin_y),
    .red(r1), .green(g1), .blue(b1), .pixel_opaque(o1)
  );

  texture_tile_renderer #(.TEX_W(16), .TEX_H(16), .NUM_TEX(3), .SCALE_LOG2(0)) u_s0 (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .tex_sel(tex_sel), .tile_en(tile_en), .origin_x(origin_x), .origin_y(origin_y),
    .red(r0), .green(g0), .blue(b0), .pixel_opaque(o0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic compare(input string dut, input int id,
                         input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d @edge %0d: got rgb=%03h opq=%b, want rgb=%03h opq=%b",
               dut, id, edge_cnt, act[12:1], act[0], exp[12:1], exp[0]);
    end
  endtask

  // Monitor: compare every expectation whose target edge has just occurred.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (q1.size() != 0 && q1[0].target <= edge_cnt) begin
      e = q1.pop_front();
      if (e.target != edge_cnt) begin
        n_cmp++; n_err++;
        $display("FAIL s1 vec%0d missed edge %0d (now %0d)", e.id, e.target, edge_cnt);
      end else if (e.chk) begin
        compare("s1", e.id, {r1, g1, b1, o1}, {e.rgb, e.opq});
      end
    end
    while (q0.size() != 0 && q0[0].target <= edge_cnt) begin
      e = q0.pop_front();
      if (e.target != edge_cnt) begin
        n_cmp++; n_err++;
        $display("FAIL s0 vec%0d missed edge %0d (now %0d)", e.id, e.target, edge_cnt);
      end else if (e.chk) begin
        compare("s0", e.id, {r0, g0, b0, o0}, {e.rgb, e.opq});
      end
    end
  end

  task automatic push_zero(input int target);
    exp_t e;
    e.target = target; e.chk = 1'b1; e.rgb = 12'h000; e.opq = 1'b0; e.id = -1;
    q1.push_back(e);
    q0.push_back(e);
  endtask

  // Drive one sample at a negedge and queue the expected result 3 edges on.
  task automatic apply(input int x, input int y, input logic b, input logic te,
                       input int ox, input int oy, input int sel,
                       input bit c1, input logic [11:0] rgb1, input logic op1,
                       input bit c0, input logic [11:0] rgb0, input logic op0);
    exp_t e;
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    blank    = b;
    tile_en  = te;
    origin_x = 10'(ox);
    origin_y = 10'(oy);
    tex_sel  = 2'(sel);
    e.target = edge_cnt + 3;
    e.id     = vec_id;
    e.chk = c1; e.rgb = rgb1; e.opq = op1; q1.push_back(e);
    e.chk = c0; e.rgb = rgb0; e.opq = op0; q0.push_back(e);
    vec_id++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; blank = 1'b1; tile_en = 1'b0; tex_sel = 2'd0;
    DrawX = 10'd37; DrawY = 10'd9; origin_x = 10'd0; origin_y = 10'd0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_zero(edge_cnt + 1);
      @(negedge clk);
    end
    // Release mid-frame: two more zero cycles before the first real pixel.
    reset = 1'b0;
    push_zero(edge_cnt + 1);
    push_zero(edge_cnt + 2);

    // Single copy, origin (100,50): footprint edges and texel sampling.
    apply( 99, 50, 1, 0, 100, 50, 0,  1, BG,     0,       1, BG,     0);
    apply(100, 50, 1, 0, 100, 50, 0,  1, E0_RGB, E0_OPQ,  1, E0_RGB, E0_OPQ);
    apply(131, 50, 1, 0, 100, 50, 0,  1, 12'hF0D, 1,      1, BG,     0);
    apply(132, 50, 1, 0, 100, 50, 0,  1, BG,     0,       1, BG,     0);
    apply(102, 51, 1, 0, 100, 50, 0,  1, 12'h1E3, 1,      1, 12'h4BC, 1);
    // Tiled: row wrap and negative-dx wrap.
    apply( 16, 17, 1, 1,   0,  0, 0,  1, 12'h878, 1,      1, 12'h2D6, 1);
    apply(  0,  3, 1, 1,   5,  0, 0,  1, 12'hF0D, 1,      1, 12'h1E3, 1);
    // One blanked cycle mid-line.
    apply(200, 21, 1, 1,   0,  0, 0,  1, 12'h878, 1,      1, 12'h2D6, 1);
    apply(201, 21, 0, 1,   0,  0, 0,  1, 12'h000, 0,      1, 12'h000, 0);
    apply(202, 21, 1, 1,   0,  0, 0,  1, 12'h96B, 1,      1, 12'h4BC, 1);
    apply(203, 21, 1, 1,   0,  0, 0,  1, 12'h96B, 1,      1, 12'h5AF, 1);
    // Texture change only at the frame boundary; out-of-range select ignored.
    apply(320, 100, 1, 1,  0,  0, 2,  1, 12'h4BC, 1,      1, 12'h878, 1);
    apply(  0,  0, 1, 1,   0,  0, 2,  1, 12'hA5E, 1,      1, 12'hA5E, 1);
    apply(  1,  0, 1, 1,   0,  0, 2,  1, 12'hA5E, 1,      1, 12'hB41, 1);
    apply(  0,  0, 1, 1,   0,  0, 3,  1, 12'hA5E, 1,      1, 12'hA5E, 1);
    apply(  3,  0, 1, 1,   0,  0, 0,  1, 12'hB41, 1,      1, 12'hD27, 1);
    apply(  0,  0, 1, 1,   0,  0, 0,  1, E0_RGB, E0_OPQ,  1, E0_RGB, E0_OPQ);

    blank = 1'b0;
    for (int i = 0; i < 10 && (q1.size() != 0 || q0.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q0.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d/%0d expectations left, want 0", q1.size(), q0.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
